odd_issue_ctrl: RTL
===================

# odd_issue_ctrl

Issue controller in front of the odd pipe (`oddpipe`). It accepts decoded odd-pipe instructions through a one-entry valid/ready buffer and tracks in-flight destinations in a 7-stage shadow of the pipe. An instruction issues only when its sources can be read from the register file or one of the forwarding taps `fw_op_st_1..7`. A taken branch flushes the buffer and the younger shadow entries.

## Interface
Parameters:
- OP_DEPTH, 7: odd-pipe depth; shadow entries and forwarding taps.
- BRANCH_STAGE, 3: shadow age at which `branch_taken` is reported; entries younger than this are flushed.

Ports:
- clock  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded odd instruction offered.
- in_ready  out  1  buffer can accept this cycle.
- in_op_code  in  opcode  instruction opcode (`descriptions::opcode`).
- in_ra_addr, in_rb_addr, in_rt_addr  in  7 each  source and destination registers.
- in_uses_ra, in_uses_rb, in_writes_rt  in  1 each  operand-use and writeback flags.
- in_latency  in  3  result-ready stage, 1..7. 0 is illegal and is treated as 7.
- branch_taken  in  1  from `oddpipe`.
- issue_valid  out  1  instruction presented to `oddpipe` this cycle.
- issue_op_code  out  opcode  pending opcode; `issue_valid`=0 marks it as a NOP.
- issue_ra_addr, issue_rb_addr, issue_rt_addr  out  7 each  pending register fields.
- stall  out  1  pending instruction blocked by a hazard.
- flush  out  1  registered; asserted the cycle after `branch_taken`.

## Operation
Pending buffer (one entry):
- Accept when `in_valid && in_ready`.
- `in_ready` = `!pend_valid || issue_fire`. It is combinational and equals 1 in reset.

Issue rule:
- `hazard` = some `shadow[a]` (a = 1..OP_DEPTH) has `valid && writes_rt` and `rt` matches a used source (`ra` if `uses_ra`, `rb` if `uses_rb`) and `a < latency`.
- `issue_fire` = `pend_valid && !hazard && !branch_taken`.
- `issue_valid` = `issue_fire`.
- `stall` = `pend_valid && hazard`.

Shadow pipe:
- Every cycle, entry a moves to a+1 and the entry at OP_DEPTH retires.
- Entry 1 loads `{issue_fire, rt, writes_rt, latency}`.
- Sources whose producer has retired are read from the register file, which is always hazard-free.

Branch:
- `branch_taken` clears `pend_valid` and invalidates shadow entries with age < BRANCH_STAGE, in that same edge.
- No issue occurs in the `branch_taken` cycle.
- An input handshake in that cycle is accepted and then discarded.

Other rules:
- WAW is not tracked. Two in-flight writers to the same `rt` are legal; the youngest matching hazard governs.
- Hazard detection ignores register 0 only if the ISA defines it as constant. It does not, so all 128 registers are checked.

## Timing
- Accept at edge N → `pend_valid` at N+1 → `issue_valid` in cycle N+1 when there is no hazard. Throughput is 1 instruction per cycle.
- Dependent op with producer latency L: issues exactly L cycles after the producer's issue cycle.
- Reset (asynchronous, any time): `pend_valid`=0, all shadow entries invalid, `issue_valid`=0, `stall`=0, `flush`=0, issue fields 0. In-flight state is lost.
- `branch_taken` and a new `in_valid` in the same cycle: flush wins; the input is dropped.
- Hazard clears and `branch_taken` occur in the same cycle: no issue.

## Configuration
- `ODD_ISSUE_PERF_EN`
  - Defined: adds 32-bit saturating counters `perf_issued` and `perf_stall_cycles` as outputs. Both reset to 0 and increment on `issue_fire` and on `stall` respectively.
  - Undefined: the ports and logic are absent; behaviour is otherwise identical.

## Structure
- `descriptions` package:
  - `OP_DEPTH` default constant.
  - `odd_shadow_t` struct `{valid, writes_rt, rt[0:6], lat[0:2]}`.
  - Function `odd_latency(opcode)`: permute/shift/rotate/gather ops 4, load/store 6, branches 1. Decode uses it to drive `in_latency`.
- Sub-module `odd_shadow_pipe`: shift register, age-qualified compare against two source addresses, partial flush.

## Test plan
- Independent stream of `SHIFT_LEFT_QUADWORD_BY_BITS` rt=5, then `ROTATE_QUADWORD_BY_BYTES` ra=9, one per cycle → `issue_valid` high on consecutive cycles, `stall` never asserted.
- Producer rt=12 with L=4 issued at cycle T, consumer ra=12 pending at T+1 → `stall` high for T+1..T+3, issue at T+4.
- Consumer rb=12 after load rt=12 with L=6 → issues at T+6; with `uses_rb`=0 → issues at T+1.
- `branch_taken` at cycle B with the pending op valid and shadow ages 1,2 valid → `pend_valid`=0 and those entries invalid at B+1, `flush`=1 at B+1, age-3 entry kept.
- Async reset pulled low mid-stall → all outputs 0 immediately, `in_ready`=1, first op after release issues with no stall.
- With `ODD_ISSUE_PERF_EN`: 3 issues and 3 stall cycles → `perf_issued`=3, `perf_stall_cycles`=3.

Source files
------------

// File: rtl/odd_issue_ctrl_pkg.sv
// rtl/odd_issue_ctrl_pkg.sv - shared types and decode helpers for the odd-pipe issue controller
//
// Package: descriptions
//   OP_DEPTH       default odd-pipe depth (shadow entries / forwarding taps)
//   opcode         odd-pipe opcode enumeration
//   odd_shadow_t   one in-flight destination record {valid, writes_rt, rt, lat}
//   odd_pend_t     contents of the one-entry pending buffer
//   odd_latency()  result-ready stage per opcode, used by decode to drive in_latency
package descriptions;

  localparam int OP_DEPTH = 7;

  typedef enum logic [3:0] {
    OP_NOP                      = 4'd0,
    SHIFT_LEFT_QUADWORD_BY_BITS = 4'd1,
    SHIFT_LEFT_QUADWORD_BY_BYTES= 4'd2,
    ROTATE_QUADWORD_BY_BITS     = 4'd3,
    ROTATE_QUADWORD_BY_BYTES    = 4'd4,
    SHUFFLE_BYTES               = 4'd5,
    GATHER_BITS_FROM_WORDS      = 4'd6,
    LOAD_QUADWORD               = 4'd7,
    STORE_QUADWORD              = 4'd8,
    BRANCH_RELATIVE             = 4'd9,
    BRANCH_INDIRECT             = 4'd10
  } opcode;

  typedef struct packed {
    logic       valid;
    logic       writes_rt;
    logic [6:0] rt;
    logic [2:0] lat;
  } odd_shadow_t;

  typedef struct packed {
    opcode      op;
    logic [6:0] ra;
    logic [6:0] rb;
    logic [6:0] rt;
    logic       uses_ra;
    logic       uses_rb;
    logic       writes_rt;
    logic [2:0] lat;
  } odd_pend_t;

  function automatic logic [2:0] odd_latency(input opcode op);
    case (op)
      LOAD_QUADWORD, STORE_QUADWORD:    odd_latency = 3'd6;
      BRANCH_RELATIVE, BRANCH_INDIRECT: odd_latency = 3'd1;
      default:                          odd_latency = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/odd_issue_ctrl_shadow_pipe.sv
// rtl/odd_issue_ctrl_shadow_pipe.sv - in-flight destination shadow of the odd pipe with hazard compare
//
// Module: odd_shadow_pipe
//   clock, reset     clock, asynchronous active-low reset
//   load_i           record entering age 1 this edge
//   kill_young_i     invalidate entries younger than KILL_AGE in this edge
//   ra_addr_i/uses_ra_i, rb_addr_i/uses_rb_i   source operands of the pending op
//   hazard_o         a used source is not yet readable from any tap or the register file
module odd_shadow_pipe
  import descriptions::*;
#(
  parameter int DEPTH    = 7,
  parameter int KILL_AGE = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  odd_shadow_t load_i,
  input  logic        kill_young_i,
  input  logic [6:0]  ra_addr_i,
  input  logic        uses_ra_i,
  input  logic [6:0]  rb_addr_i,
  input  logic        uses_rb_i,
  output logic        hazard_o
);

  odd_shadow_t shadow_q [1:DEPTH];
  odd_shadow_t shadow_d [1:DEPTH];
  logic        ra_haz;
  logic        rb_haz;

  // Shift by one age per cycle; ages below KILL_AGE are wrong-path on a branch.
  always_comb begin
    shadow_d[1] = load_i;
    for (int a = 1; a < DEPTH; a++) begin
      shadow_d[a+1] = shadow_q[a];
      if (kill_young_i && (a < KILL_AGE)) shadow_d[a+1].valid = 1'b0;
    end
  end

  // Scan oldest to youngest so the youngest matching writer decides (WAW is legal).
  // An entry of age a has its result on a tap once a >= lat.
  always_comb begin
    ra_haz = 1'b0;
    rb_haz = 1'b0;
    for (int a = DEPTH; a >= 1; a--) begin
      if (shadow_q[a].valid && shadow_q[a].writes_rt) begin
        if (shadow_q[a].rt == ra_addr_i) ra_haz = (a < int'(shadow_q[a].lat));
        if (shadow_q[a].rt == rb_addr_i) rb_haz = (a < int'(shadow_q[a].lat));
      end
    end
    hazard_o = (uses_ra_i && ra_haz) || (uses_rb_i && rb_haz);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int a = 1; a <= DEPTH; a++) shadow_q[a] <= '0;
    end else begin
      for (int a = 1; a <= DEPTH; a++) shadow_q[a] <= shadow_d[a];
    end
  end

endmodule

// File: rtl/odd_issue_ctrl.sv
// rtl/odd_issue_ctrl.sv - issue controller in front of the odd pipe
//
// Module: odd_issue_ctrl  (optional macro: ODD_ISSUE_PERF_EN adds perf counters)
//   clock, reset                   clock, asynchronous active-low reset
//   in_valid/in_ready              one-entry pending buffer handshake
//   in_op_code, in_r{a,b,t}_addr   decoded instruction fields
//   in_uses_ra/rb, in_writes_rt    operand-use and writeback flags
//   in_latency                     result-ready stage 1..7 (0 means 7)
//   branch_taken                   from the odd pipe; flushes buffer and young shadow entries
//   issue_valid, issue_*           pending instruction presented to the pipe
//   stall                          pending instruction blocked by a hazard
//   flush                          registered copy of branch_taken
//   perf_issued, perf_stall_cycles saturating counters (ODD_ISSUE_PERF_EN only)
module odd_issue_ctrl
  import descriptions::*;
#(
  parameter int OP_DEPTH     = descriptions::OP_DEPTH,
  parameter int BRANCH_STAGE = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  opcode       in_op_code,
  input  logic [6:0]  in_ra_addr,
  input  logic [6:0]  in_rb_addr,
  input  logic [6:0]  in_rt_addr,
  input  logic        in_uses_ra,
  input  logic        in_uses_rb,
  input  logic        in_writes_rt,
  input  logic [2:0]  in_latency,
  input  logic        branch_taken,
  output logic        issue_valid,
  output opcode       issue_op_code,
  output logic [6:0]  issue_ra_addr,
  output logic [6:0]  issue_rb_addr,
  output logic [6:0]  issue_rt_addr,
  output logic        stall,
  output logic        flush
`ifdef ODD_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall_cycles
`endif
);

  odd_pend_t   pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic        flush_q;
  logic        hazard;
  logic        issue_fire;
  logic        accept;
  odd_shadow_t shadow_load;

  assign issue_fire = pend_valid_q && !hazard && !branch_taken;
  assign in_ready   = !pend_valid_q || issue_fire;
  assign accept     = in_valid && in_ready;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    if (issue_fire) pend_valid_d = 1'b0;
    if (accept) begin
      pend_valid_d     = 1'b1;
      pend_d.op        = in_op_code;
      pend_d.ra        = in_ra_addr;
      pend_d.rb        = in_rb_addr;
      pend_d.rt        = in_rt_addr;
      pend_d.uses_ra   = in_uses_ra;
      pend_d.uses_rb   = in_uses_rb;
      pend_d.writes_rt = in_writes_rt;
      pend_d.lat       = (in_latency == 3'd0) ? 3'd7 : in_latency;
    end
    // A handshake in the branch cycle is taken but belongs to the wrong path.
    if (branch_taken) pend_valid_d = 1'b0;
  end

  always_comb begin
    shadow_load.valid     = issue_fire;
    shadow_load.writes_rt = pend_q.writes_rt;
    shadow_load.rt        = pend_q.rt;
    shadow_load.lat       = pend_q.lat;
  end

  odd_shadow_pipe #(
    .DEPTH    (OP_DEPTH),
    .KILL_AGE (BRANCH_STAGE)
  ) u_shadow (
    .clock        (clock),
    .reset        (reset),
    .load_i       (shadow_load),
    .kill_young_i (branch_taken),
    .ra_addr_i    (pend_q.ra),
    .uses_ra_i    (pend_q.uses_ra),
    .rb_addr_i    (pend_q.rb),
    .uses_rb_i    (pend_q.uses_rb),
    .hazard_o     (hazard)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      flush_q      <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      flush_q      <= branch_taken;
    end
  end

  assign issue_valid   = issue_fire;
  assign issue_op_code = pend_q.op;
  assign issue_ra_addr = pend_q.ra;
  assign issue_rb_addr = pend_q.rb;
  assign issue_rt_addr = pend_q.rt;
  assign stall         = pend_valid_q && hazard;
  assign flush         = flush_q;

`ifdef ODD_ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (issue_fire && (perf_issued_q != '1)) perf_issued_q <= perf_issued_q + 32'd1;
      if (stall && (perf_stall_q != '1))       perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued       = perf_issued_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  // No counters in this build.
`endif

endmodule
